uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Serial UART receiver with an on-chip receive FIFO. It is the far end of the usb2uart
//  bridge's uart_tx line (io[20] loop-back or an external pin).
//  Oversamples the 8N1 stream, validates start and stop bits, and buffers received bytes
//  in a show-ahead FIFO. Reports framing and overrun errors.
//  Runs in the 48 MHz user_clock2 domain alongside usb2uart.
// PARAMETERS
//  CLKS_PER_BIT  417  clk cycles per bit (48 MHz / 115200 baud); legal range >= 8
//  DEPTH         16   FIFO entries; power of two, >= 2
// PORTS
//  clk         in   1   48 MHz clock
//  rst_n       in   1   asynchronous active-low reset
//  rx_i        in   1   serial input, idles high, asynchronous to clk
//  rd_en       in   1   pop request; honoured only while rd_valid=1
//  rd_data     out  8   FIFO head byte; valid while rd_valid=1
//  rd_valid    out  1   FIFO not empty
//  fifo_level  out  $clog2(DEPTH)+1  number of stored bytes, 0..DEPTH
//  frame_err   out  1   1-cycle pulse: stop bit sampled low
//  parity_err  out  1   1-cycle pulse: parity mismatch (tied 0 when feature absent)
//  overrun     out  1   sticky: byte dropped because FIFO was full
//  clr_err     in   1   clears overrun (clr_err wins over a same-cycle set)
// BEHAVIOUR
//  Reset values: rd_data=0, rd_valid=0, fifo_level=0, frame_err=0, parity_err=0, overrun=0.
//    FSM enters IDLE; synchroniser flops are set to 1.
//  Sync: rx_i passes through a 2-flop synchroniser (rx_s); all logic uses rx_s only.
//  FSM states: IDLE, START, DATA, [PARITY], STOP, BREAK.
//   IDLE:   rx_s==0 -> START; bit counter cleared.
//   START:  at count CLKS_PER_BIT/2 (integer divide), sample rx_s.
//           1 -> glitch: IDLE, no flag. 0 -> DATA; counter restarts.
//   DATA:   sample every CLKS_PER_BIT cycles (mid-bit); 8 bits, LSB first, shifted into the
//           shift register. After bit 7 -> PARITY when the feature is present, else -> STOP.
//   STOP:   sample at mid-bit.
//           1 -> push byte (subject to full/parity rules) and go to IDLE.
//           0 -> frame_err pulse, byte discarded, go to BREAK.
//   BREAK:  wait for rx_s==1, then IDLE. No bytes are pushed while in BREAK.
//  Push timing: the byte is written on the STOP-sample edge; rd_valid/fifo_level update on
//    that same edge (visible the next cycle).
//  Latency: falling edge on rx_i -> rd_valid high in ~9.5*CLKS_PER_BIT + 3 cycles.
//  FIFO: show-ahead; rd_data always shows the head entry.
//    Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full when level==DEPTH.
//   pop while empty: ignored, no state change.
//   push while full, no pop: byte dropped, overrun set, level stays DEPTH.
//   push and pop same cycle, any level including full: both take effect, level unchanged,
//     no overrun.
//   push and pop same cycle at level 0: not possible (pop is ignored when empty); push only.
//  Reset mid-frame: FSM returns to IDLE and the FIFO empties immediately (asynchronous).
//    After rst_n release, a line held low is treated as a fresh start bit.
//  Counters: bit-timer width is $clog2(CLKS_PER_BIT); it terminates at CLKS_PER_BIT-1.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    Frame is 8E1. The PARITY state samples the bit after bit 7.
//    Mismatch with even parity over the 8 data bits -> parity_err pulse at the STOP sample;
//      byte discarded.
//    Frame error takes precedence: only frame_err pulses, never both.
//  UART_RX_PARITY_EN undefined:
//    Frame is 8N1; no PARITY state; parity_err is constant 0.
// TESTING  (CLKS_PER_BIT=16, DEPTH=4 in bench)
//  1 Send 0xA5 8N1 -> rd_valid rises ~155 cycles after the start edge; rd_data=0xA5; level=1.
//    rd_en -> level=0.
//  2 rx_i low pulse of 5 cycles -> no byte, no error pulse, FSM back in IDLE.
//  3 Send 0x3C with stop bit held low for 40 cycles -> frame_err 1-cycle pulse, level=0.
//    Next byte 0x01 received correctly once the line returns high.
//  4 Send 5 bytes 0x10..0x14 with no reads -> level=4, overrun=1, head=0x10.
//    Drain gives 0x10..0x13. clr_err -> overrun=0.
//  5 Level=4; hold rd_en so a pop coincides with the push of 0x55 -> level stays 4, overrun=0,
//    0x55 is the last entry.
//  6 Assert rst_n=0 during DATA of byte 0x77 -> outputs return to reset values.
//    After release, 0x88 is received intact.
//    With UART_RX_PARITY_EN: 0x81 with parity bit 1 -> parity_err pulse, byte discarded.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, oversampled) feeding a show-ahead byte FIFO with framing/overrun reporting.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive parity_err.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 417,
  parameter int unsigned DEPTH        = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_i,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     frame_err,
  output logic                     parity_err,
  output logic                     overrun,
  input  logic                     clr_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t           state, state_n;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic             push_c, ferr_c;
`ifdef UART_RX_PARITY_EN
  logic             par_bit, par_bit_n, perr_c;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      frame_err <= ferr_c;
`ifdef UART_RX_PARITY_EN
      par_bit    <= par_bit_n;
      parity_err <= perr_c;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    push_c    = 1'b0;
    ferr_c    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_n = par_bit;
    perr_c    = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n     = '0;
        bit_idx_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n     = '0;
          shift_n   = {rx_s, shift[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == LAST) begin
          cnt_n     = '0;
          par_bit_n = rx_s;
          state_n   = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
            // even parity: data plus parity bit must hold an even number of ones
            if (^{shift, par_bit}) perr_c = 1'b1;
            else                   push_c = 1'b1;
`else
            push_c = 1'b1;
`endif
          end else begin
            ferr_c  = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, do_pop, do_push;

  assign full     = (fifo_level == (PTR_W+1)'(DEPTH));
  assign rd_valid = (fifo_level != '0);
  assign do_pop   = rd_en && rd_valid;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_push  = push_c && (!full || do_pop);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overrun    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (clr_err)                         overrun <= 1'b0;
      else if (push_c && full && !do_pop)  overrun <= 1'b1;
    end
  end

endmodule
